// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  // Stream bytes per instruction word.
  localparam int BYTES_PER_WORD = 4;
  // Byte distance between consecutive instruction words (pc increment).
  localparam int ADDR_STEP = 4;

  // States in which the loader takes bytes from the stream.
  function automatic logic is_intake(input state_t s);
    return (s == HDR0) || (s == HDR1) || (s == DATA);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs little-endian stream bytes into 32-bit words. Byte k of a word lands
// in bits [8k+7:8k]; word/word_complete present the finished word in the same
// cycle its last byte is accepted so the caller can register it directly.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  in_byte,
  input  logic        accept,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [1:0]  byte_cnt;
  logic [31:0] word_q;

  // Merge the incoming byte into the held partial word at its lane.
  always_comb begin
    word          = word_q;
    word_complete = 1'b0;
    if (accept) begin
      word[{byte_cnt, 3'b000} +: 8] = in_byte;
      word_complete = (byte_cnt == 2'(BYTES_PER_WORD - 1));
    end
  end

  // Byte lane counter and partial-word storage; a gap in accept holds both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      word_q   <= 32'd0;
    end else if (clr) begin
      byte_cnt <= 2'd0;
    end else if (accept) begin
      word_q   <= word;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction memory writer: header (word count) then words, each
// written through a one-cycle strobe; the core is held until the last write.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready is registered: it is 1 only while the FSM sits in an intake state
// (HDR0/HDR1/DATA) and will still be in one after the edge, so it drops in the
// same edge that leaves intake and never advertises a slot the FSM would
// ignore. A consequence is one idle cycle after entering HDR0.
module im_loader #(
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 we,
  output logic [15:0]          waddr,
  output logic [ROM_WIDTH-1:0] wdata,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err
);

  import loader_pkg::*;

  localparam int IDX_W = $clog2(ROM_ADDR_BITS) + 1;

  state_t            state, next_state;
  logic [15:0]       hdr_cnt;
  logic [15:0]       hdr_full;
  logic [IDX_W-1:0]  word_idx;
  logic              intake;
  logic              asm_accept;
  logic              asm_clr;
  logic [31:0]       asm_word;
  logic              word_complete;
  logic              last_word;

  assign intake     = in_valid && in_ready;
  assign asm_accept = intake && (state == DATA);
  assign asm_clr    = (state != DATA);
  // Full word count as it becomes known while the MSB byte is taken.
  assign hdr_full   = {in_data, hdr_cnt[7:0]};
  assign last_word  = (16'(word_idx) == (hdr_cnt - 16'd1));

  word_assembler u_asm (
    .clk           (clk),
    .rst           (rst),
    .clr           (asm_clr),
    .in_byte       (in_data),
    .accept        (asm_accept),
    .word          (asm_word),
    .word_complete (word_complete)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: header parsing, word counting, re-arm on start.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = HDR0;
      HDR0:  if (intake) next_state = HDR1;
      HDR1: begin
        if (intake) begin
          if (hdr_full == 16'd0)                      next_state = DONE;
          else if (hdr_full > 16'(ROM_ADDR_BITS))     next_state = ERR;
          else                                        next_state = DATA;
        end
      end
      DATA:  if (word_complete && last_word) next_state = FLUSH;
      FLUSH: next_state = DONE;
      DONE:  if (start) next_state = HDR0;
      ERR:   if (start) next_state = HDR0;
      default: next_state = IDLE;
    endcase
  end

  // Header count capture and word index; index restarts with each header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_cnt  <= 16'd0;
      word_idx <= '0;
    end else begin
      if (intake && state == HDR0) hdr_cnt <= {8'h00, in_data};
      if (intake && state == HDR1) begin
        hdr_cnt  <= hdr_full;
        word_idx <= '0;
      end
      if (word_complete) word_idx <= word_idx + 1'b1;
    end
  end

  // Write port: word and address captured with the 4th byte, strobe for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= 16'd0;
      wdata <= '0;
    end else begin
      we <= word_complete;
      if (word_complete) begin
        waddr <= 16'(word_idx) * 16'(ADDR_STEP);
        wdata <= asm_word;
      end
    end
  end

  // Registered status outputs, aligned with the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      in_ready <= is_intake(state) && is_intake(next_state);
      cpu_hold <= (next_state != DONE);
      done     <= (next_state == DONE);
      err      <= (next_state == ERR);
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: byte driver, write-port scoreboard, status checks.
module tb_im_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        we;
  logic [15:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected writes: {waddr, wdata}
  logic [47:0] exp_q[$];
  logic        prev_we;

  im_loader #(.ROM_WIDTH(32), .ROM_ADDR_BITS(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Packed view of all outputs against their reset values.
  task automatic check_reset_vals(input string tag);
    check(tag, {11'b0, in_ready, we, waddr, wdata, cpu_hold, done, err},
               {11'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b0});
  endtask

  // Driver: optional idle gap, present byte, wait (bounded) for acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_wait", {63'b0, in_ready}, 64'd1);
    else @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, max_gap));
  endtask

  task automatic release_valid();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scoreboard: every write strobe must match the next expected write.
  always @(negedge clk) begin
    logic [47:0] e;
    if (rst === 1'b0) begin
      if (we === 1'b1) begin
        check("we_expected", {63'b0, (exp_q.size() != 0)}, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_port", {16'b0, waddr, wdata}, {16'b0, e});
        end
        check("we_single_cycle", {63'b0, prev_we}, 64'd0);
      end
      prev_we <= we;
    end else begin
      prev_we <= 1'b0;
    end
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;

    // Reset values, then in_ready rises two edges after release
    repeat (2) @(negedge clk);
    check_reset_vals("reset_values");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_1_edge", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    check("ready_after_2_edges", {63'b0, in_ready}, 64'd1);

    // N=3 load, in_valid held high
    exp_q.push_back({16'h0000, 32'h00300413});
    exp_q.push_back({16'h0004, 32'h00100493});
    exp_q.push_back({16'h0008, 32'h01000913});
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_word(32'h00300413, 0);
    send_word(32'h00100493, 0);
    send_word(32'h01000913, 0);
    release_valid();
    check("n3_flush_hold", {62'b0, done, cpu_hold}, {62'b0, 1'b0, 1'b1});
    @(negedge clk);
    check("n3_done", {61'b0, done, cpu_hold, in_ready}, {61'b0, 1'b1, 1'b0, 1'b0});
    check("n3_all_written", 64'(exp_q.size()), 64'd0);

    // start with in_valid in DONE: start wins, byte refused
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check("rearm_from_done", {61'b0, done, cpu_hold, err}, {61'b0, 1'b0, 1'b1, 1'b0});

    // N=0: header only, straight to DONE with no writes
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    release_valid();
    check("n0_done", {60'b0, done, cpu_hold, err, in_ready}, {60'b0, 1'b1, 1'b0, 1'b0, 1'b0});

    // N=65 exceeds 64-word memory: error, bytes refused
    pulse_start();
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    release_valid();
    check("n65_err", {60'b0, err, in_ready, cpu_hold, done}, {60'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    in_data  = 8'h99;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("err_refuses_bytes", {62'b0, err, in_ready}, {62'b0, 1'b1, 1'b0});
    in_valid = 1'b0;
    pulse_start();
    check("err_cleared_by_start", {62'b0, err, cpu_hold}, {62'b0, 1'b0, 1'b1});

    // N=2 with random in_valid gaps inside words
    exp_q.push_back({16'h0000, 32'hDEADBEEF});
    exp_q.push_back({16'h0004, 32'h12345678});
    send_byte(8'h02, $urandom_range(0, 2));
    send_byte(8'h00, $urandom_range(0, 2));
    send_word(32'hDEADBEEF, 3);
    send_word(32'h12345678, 3);
    release_valid();
    @(negedge clk);
    check("gaps_done", {62'b0, done, cpu_hold}, {62'b0, 1'b1, 1'b0});
    check("gaps_all_written", 64'(exp_q.size()), 64'd0);

    // N=4 load interrupted by reset after 6 data bytes
    pulse_start();
    exp_q.push_back({16'h0000, 32'hA1B2C3D4});
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_word(32'hA1B2C3D4, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check_reset_vals("async_reset_values");
    check("partial_first_word_written", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fresh N=1 load after reset starts at address 0
    exp_q.push_back({16'h0000, 32'hCAFEF00D});
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'hCAFEF00D, 0);
    release_valid();
    @(negedge clk);
    check("n1_done", {62'b0, done, cpu_hold}, {62'b0, 1'b1, 1'b0});
    repeat (3) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time writer for the instruction memory. Receives a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and drives a synchronous write port into the instruction memory at byte addresses that step by 4, matching the address the fetch side presents as `pc`. Holds the core in reset (`cpu_hold`) until the image is fully written, then releases it.

## Interface
- `ROM_WIDTH`, 32: instruction word width. Fixed at 32; other values are unsupported.
- `ROM_ADDR_BITS`, 64: memory depth in words. Must be a power of 2, ≤ 16384.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse; re-arms the loader from DONE or ERR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  one-cycle write strobe to instruction memory.
- `waddr`  out  16  byte address (word index << 2).
- `wdata`  out  32  assembled word.
- `cpu_hold`  out  1  core held in reset while 1.
- `done`  out  1  image fully written.
- `err`  out  1  header word count exceeded `ROM_ADDR_BITS`.

## Operation
- Stream format: 2-byte word count N (LSB first), followed by 4·N bytes, each word LSB first.
- A byte is accepted on a rising edge where `in_valid && in_ready`. `in_ready` is a registered output equal to state ∈ {HDR0, HDR1, DATA}.
- States:
  - IDLE: reset state. Goes to HDR0 unconditionally after 1 cycle.
  - HDR0: accept byte → cnt[7:0], then go to HDR1.
  - HDR1: accept byte → cnt[15:8], then:
    - N = 0 → DONE;
    - N > `ROM_ADDR_BITS` → ERR;
    - otherwise DATA.
  - DATA: a 2-bit byte counter shifts bytes into the word, byte k into bits [8k+7:8k]. On the 4th byte:
    - the word and its address are registered and `we` is pulsed the following cycle;
    - the word index increments;
    - if this was word N-1, go to FLUSH.
  - FLUSH: 1 cycle; covers the final `we` pulse. Then DONE.
  - DONE: `done`=1, `cpu_hold`=0. `start` → HDR0, with `done` cleared and `cpu_hold` reasserted.
  - ERR: `err`=1, `cpu_hold`=1, bytes refused. `start` → HDR0, with `err` cleared.
- `start` is ignored in IDLE, HDR0, HDR1, DATA and FLUSH.
- `start` together with `in_valid` in DONE/ERR: `start` wins and the byte is not accepted, because `in_ready`=0.
- Word index is `$clog2(ROM_ADDR_BITS)`+1 bits wide. `waddr` = index·4, zero-extended to 16 bits.
- Back-to-back bytes with `in_valid` held high sustain 1 byte/cycle. A write never stalls intake.
- Gaps in `in_valid` pause assembly with no timeout. Partial words are retained.
- Reset asserted mid-load:
  - all state is cleared immediately and the partial image is abandoned;
  - memory already written is not erased;
  - `cpu_hold` returns to 1.

## Timing
- Reset values: `in_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `cpu_hold`=1, `done`=0, `err`=0.
- `in_ready` rises 2 edges after reset deasserts (IDLE→HDR0, then the registered output updates).
- 4th byte of a word accepted at edge E: `we`=1 with valid `waddr`/`wdata` between edges E and E+1.
- Final word's 4th byte at edge E: `we` pulses during E→E+1 (FLUSH); `done`=1 and `cpu_hold`=0 from edge E+1 onward. The memory therefore holds the full image before the core is released.
- `we` is never high for 2 consecutive cycles.
- `waddr`/`wdata` hold their last value when `we`=0.

## Structure
- Shared package `loader_pkg` holds:
  - state enum (IDLE, HDR0, HDR1, DATA, FLUSH, DONE, ERR), 3 bits;
  - `BYTES_PER_WORD`=4;
  - `ADDR_STEP`=4 (pc increment).
- One sub-module, `word_assembler`: 2-bit byte counter plus a 32-bit shift/insert register.
  - Inputs: byte and accept strobe.
  - Outputs: word and `word_complete` pulse.
  - Top level owns the FSM, word index, header count and write-port registers.

## Test plan
- Load N=3: stream 03 00, then 13 04 30 00 / 93 04 10 00 / 13 09 00 01 with `in_valid` held high.
  - Expect 3 `we` pulses: `waddr`=0x0000, 0x0004, 0x0008 with `wdata`=0x00300413, 0x00100493, 0x01000913.
  - Expect `done`=1 and `cpu_hold`=0 one cycle after the last `we`.
- N=0: stream 00 00 → DONE entered after HDR1, no `we`, `cpu_hold`=0.
- N=65 with `ROM_ADDR_BITS`=64: stream 41 00 → `err`=1, `in_ready`=0, `cpu_hold`=1, no `we`. A `start` pulse returns to HDR0 with `err`=0.
- Randomised `in_valid` gaps inside words, N=2: words and addresses identical to the gap-free case, and no `we` before the 4th byte of each word.
- Reset asserted asynchronously after 6 data bytes of an N=4 load: outputs return to reset values in the same cycle. A subsequent full N=1 load writes `waddr`=0.
- In DONE, `start` and `in_valid` high in the same cycle: byte not accepted, state goes to HDR0, `cpu_hold`=1. The next byte is taken as header LSB.
